// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel divider, H/V counters, registered sync/blank decode.
// Define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_sync_gen #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int CLK_DIV         = 2,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] HCount,
  output logic [9:0] VCount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pix_tick,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_timing
      $error("vga_sync_gen: totals must be <= 1024 and CLK_DIV >= 1");
    end
  endgenerate

  function automatic logic in_win(input logic [9:0] c, input int lo, input int len);
    int ci;
    ci = int'({22'd0, c});
    return (ci >= lo) && (ci < lo + len);
  endfunction

  function automatic logic sync_level(input logic act);
    return (SYNC_ACTIVE_LOW != 0) ? ~act : act;
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic             wrap;

  // next-state of divider and counters; the sync/blank registers decode these
  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    h_nxt   = HCount;
    v_nxt   = VCount;
    wrap    = 1'b0;
    if (pix_tick) begin
      if (HCount == H_LAST) begin
        h_nxt = '0;
        if (VCount == V_LAST) begin
          v_nxt = '0;
          wrap  = 1'b1;
        end else begin
          v_nxt = VCount + 10'd1;
        end
      end else begin
        h_nxt = HCount + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      pix_tick    <= 1'b0;
      HCount      <= '0;
      VCount      <= '0;
      hsync       <= sync_level(1'b0);
      vsync       <= sync_level(1'b0);
      video_on    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      pix_tick    <= (div_nxt == DIV_LAST);
      HCount      <= h_nxt;
      VCount      <= v_nxt;
      hsync       <= sync_level(in_win(h_nxt, H_VISIBLE + H_FRONT, H_SYNC));
      vsync       <= sync_level(in_win(v_nxt, V_VISIBLE + V_FRONT, V_SYNC));
      video_on    <= in_win(h_nxt, 0, H_VISIBLE) && in_win(v_nxt, 0, V_VISIBLE);
      frame_start <= wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule
